maze_player_ctrl: RTL and testbench

Input stage of the maze game, upstream of the top-level STILL/MOVE/ROTATE state machine and the renderer. Debounces the four touch buttons, turns presses into one-shot move/rotate commands, and checks moves against the maze wall vectors. Owns the player's cell position and heading, and publishes each accepted update through a valid/ready handshake.

---
 rtl/maze_pkg.sv | 25 ++
 rtl/maze_player_ctrl_if.sv | 9 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/maze_player_ctrl.sv | 157 +++++++++++++++
 tb/tb_maze_player_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared types and maze geometry helpers for the maze player input stage.
package maze_pkg;

  localparam int unsigned MAZE_W = 5;
  localparam int unsigned MAZE_H = 5;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_MOVE = 2'b01;
  localparam logic [1:0] KIND_ROT  = 2'b10;

  typedef enum logic [1:0] {HEAD_N, HEAD_E, HEAD_S, HEAD_W} heading_t;
  typedef enum logic [1:0] {CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT} cmd_t;
  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_WAIT} state_t;

  // Wall on the north side of cell (x,y); row MAZE_H is the south border.
  function automatic logic [4:0] hwall_idx(input logic [2:0] x, input logic [2:0] y);
    return 5'(y) * 5'(MAZE_W) + 5'(x);
  endfunction

  // Wall on the west side of cell (x,y); column MAZE_W is the east border.
  function automatic logic [4:0] vwall_idx(input logic [2:0] x, input logic [2:0] y);
    return 5'(y) * 5'(MAZE_W + 1) + 5'(x);
  endfunction

endpackage

// File: rtl/maze_player_ctrl_if.sv
// Update handshake from the player controller to the game state machine.
interface maze_player_ctrl_if;
  logic       upd_valid;
  logic [1:0] upd_kind;
  logic       upd_ready;

  modport master (output upd_valid, output upd_kind, input upd_ready);
  modport slave  (input upd_valid, input upd_kind, output upd_ready);
endinterface

// File: rtl/btn_debounce.sv
// Active-low button synchronizer and debouncer with a one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic reset_btn,
  input  logic btn_n_i,
  output logic rise_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // The pulse is registered on the same edge the level flips, so it lines up
  // with the first cycle the new level is visible.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ~btn_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/maze_player_ctrl.sv
// Maze player input stage: debounced buttons -> checked move/rotate -> handshake.
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned START_X         = 0,
  parameter int unsigned START_Y         = 0,
  parameter int unsigned START_HEAD      = 2
) (
  input  logic                      clk_in,
  input  logic                      reset_btn,
  input  logic [3:0]                touch_btn,
  input  logic [29:0]               hor_wall,
  input  logic [29:0]               ver_wall,
  output logic [2:0]                pos_x,
  output logic [2:0]                pos_y,
  output logic [1:0]                heading,
  output logic [7:0]                z_angle,
  maze_player_ctrl_if.master        upd,
  output logic                      blocked
);

  localparam logic [2:0] X_MAX = 3'(MAZE_W - 1);
  localparam logic [2:0] Y_MAX = 3'(MAZE_H - 1);

  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_in    (clk_in),
      .reset_btn (reset_btn),
      .btn_n_i   (touch_btn[i]),
      .rise_o    (press[i])
    );
  end

  state_t     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [2:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  heading_t   head_q, head_d;
  logic       valid_q, valid_d;
  logic [1:0] kind_q, kind_d;

  heading_t   move_dir;
  logic [2:0] tgt_x, tgt_y;
  logic       is_move, at_edge, wall_hit, move_blocked;

  // Range check is done on the current cell, so 0-1 never wraps into a legal cell.
  always_comb begin
    is_move  = (cmd_q == CMD_FWD) || (cmd_q == CMD_BACK);
    move_dir = (cmd_q == CMD_BACK) ? heading_t'(head_q ^ 2'b10) : head_q;
    tgt_x    = pos_x_q;
    tgt_y    = pos_y_q;
    at_edge  = 1'b0;
    wall_hit = 1'b0;
    case (move_dir)
      HEAD_N: begin
        at_edge  = (pos_y_q == '0);
        tgt_y    = pos_y_q - 3'd1;
        wall_hit = hor_wall[hwall_idx(pos_x_q, pos_y_q)];
      end
      HEAD_S: begin
        at_edge  = (pos_y_q >= Y_MAX);
        tgt_y    = pos_y_q + 3'd1;
        wall_hit = hor_wall[hwall_idx(pos_x_q, pos_y_q + 3'd1)];
      end
      HEAD_W: begin
        at_edge  = (pos_x_q == '0);
        tgt_x    = pos_x_q - 3'd1;
        wall_hit = ver_wall[vwall_idx(pos_x_q, pos_y_q)];
      end
      HEAD_E: begin
        at_edge  = (pos_x_q >= X_MAX);
        tgt_x    = pos_x_q + 3'd1;
        wall_hit = ver_wall[vwall_idx(pos_x_q + 3'd1, pos_y_q)];
      end
    endcase
    move_blocked = is_move && (at_edge || wall_hit);
  end

  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_FWD;
      pos_x_q <= 3'(START_X);
      pos_y_q <= 3'(START_Y);
      head_q  <= heading_t'(2'(START_HEAD));
      valid_q <= 1'b0;
      kind_q  <= KIND_NONE;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      head_q  <= head_d;
      valid_q <= valid_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    head_d  = head_q;
    valid_d = valid_q;
    kind_d  = kind_q;
    case (state_q)
      ST_IDLE: begin
        if (|press) begin
          state_d = ST_EVAL;
          if (press[0])      cmd_d = CMD_FWD;
          else if (press[1]) cmd_d = CMD_BACK;
          else if (press[2]) cmd_d = CMD_LEFT;
          else               cmd_d = CMD_RIGHT;
        end
      end
      ST_EVAL: begin
        if (move_blocked) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          valid_d = 1'b1;
          if (is_move) begin
            kind_d  = KIND_MOVE;
            pos_x_d = tgt_x;
            pos_y_d = tgt_y;
          end else begin
            kind_d = KIND_ROT;
            head_d = (cmd_q == CMD_LEFT) ? heading_t'(head_q - 2'd1)
                                         : heading_t'(head_q + 2'd1);
          end
        end
      end
      ST_WAIT: begin
        if (upd.upd_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          kind_d  = KIND_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pos_x         = pos_x_q;
    pos_y         = pos_y_q;
    heading       = head_q;
    z_angle       = {head_q, 6'b0};
    upd.upd_valid = valid_q;
    upd.upd_kind  = kind_q;
    blocked       = (state_q == ST_EVAL) && move_blocked;
  end

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Bench for maze_player_ctrl: directed scenarios plus random buttons/walls/ready.
module tb_maze_player_ctrl;

  localparam int unsigned DC = 4;
  localparam int SX = 0;
  localparam int SY = 0;
  localparam int SH = 1;

  logic        clk_in = 1'b0;
  logic        reset_btn = 1'b1;
  logic [3:0]  touch_btn = 4'hF;
  logic [29:0] hor_wall = '0;
  logic [29:0] ver_wall = '0;
  logic [2:0]  pos_x, pos_y;
  logic [1:0]  heading;
  logic [7:0]  z_angle;
  logic        blocked;
  logic [19:0] obs;

  maze_player_ctrl_if upd_bus ();

  maze_player_ctrl #(
    .DEBOUNCE_CYCLES(DC), .START_X(SX), .START_Y(SY), .START_HEAD(SH)
  ) dut (
    .clk_in(clk_in), .reset_btn(reset_btn), .touch_btn(touch_btn),
    .hor_wall(hor_wall), .ver_wall(ver_wall),
    .pos_x(pos_x), .pos_y(pos_y), .heading(heading), .z_angle(z_angle),
    .upd(upd_bus.master), .blocked(blocked)
  );

  always #5 clk_in = ~clk_in;

  assign obs = {pos_x, pos_y, heading, z_angle, upd_bus.upd_valid, upd_bus.upd_kind, blocked};

  // Reference model: player state, pending command index (-1 = none), and the
  // recent synchronized button samples used to decide debounced levels.
  int       m_x, m_y, m_head, m_pending;
  bit       m_valid, m_wait;
  bit [1:0] m_kind;
  bit [3:0] m_level, m_events, m_sync1, m_sync2;
  bit [3:0] hist[$];
  int       checks = 0;
  int       errors = 0;

  function automatic void model_reset();
    m_x = SX; m_y = SY; m_head = SH; m_pending = -1;
    m_valid = 0; m_wait = 0; m_kind = 0;
    m_level = 0; m_events = 0; m_sync1 = 0; m_sync2 = 0;
    hist.delete();
    for (int k = 0; k < int'(DC); k++) hist.push_back(4'b0);
  endfunction

  function automatic int move_dir();
    return (m_pending == 1) ? (m_head + 2) % 4 : m_head;
  endfunction

  function automatic void target(input int dir, output int tx, output int ty);
    tx = m_x; ty = m_y;
    case (dir)
      0: ty = m_y - 1;
      1: tx = m_x + 1;
      2: ty = m_y + 1;
      default: tx = m_x - 1;
    endcase
  endfunction

  function automatic bit model_blocked();
    int tx, ty, dir;
    if (m_pending < 0 || m_pending > 1) return 1'b0;
    dir = move_dir();
    target(dir, tx, ty);
    if (tx < 0 || tx > 4 || ty < 0 || ty > 4) return 1'b1;
    case (dir)
      0: return hor_wall[m_y * 5 + m_x];
      2: return hor_wall[(m_y + 1) * 5 + m_x];
      3: return ver_wall[m_y * 6 + m_x];
      default: return ver_wall[m_y * 6 + m_x + 1];
    endcase
  endfunction

  function automatic void model_edge();
    bit [3:0] rose;
    int tx, ty;
    bit all_diff;
    if (m_wait) begin
      if (upd_bus.upd_ready) begin m_wait = 0; m_valid = 0; m_kind = 0; end
    end else if (m_pending >= 0) begin
      if (!model_blocked()) begin
        if (m_pending < 2) begin
          target(move_dir(), tx, ty);
          m_x = tx; m_y = ty; m_kind = 2'b01;
        end else begin
          m_head = (m_pending == 2) ? (m_head + 3) % 4 : (m_head + 1) % 4;
          m_kind = 2'b10;
        end
        m_valid = 1; m_wait = 1;
      end
      m_pending = -1;
    end else if (m_events != 0) begin
      for (int i = 3; i >= 0; i--) if (m_events[i]) m_pending = i;
    end
    hist.push_back(m_sync2);
    void'(hist.pop_front());
    rose = '0;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1;
      foreach (hist[k]) if (hist[k][i] == m_level[i]) all_diff = 0;
      if (all_diff) begin
        m_level[i] = ~m_level[i];
        rose[i] = m_level[i];
      end
    end
    m_events = rose;
    m_sync2 = m_sync1;
    m_sync1 = ~touch_btn;
  endfunction

  function automatic logic [19:0] exp_vec();
    bit b;
    b = (m_pending == 0 || m_pending == 1) && model_blocked();
    return {3'(m_x), 3'(m_y), 2'(m_head), 8'(m_head * 64), m_valid, m_kind, b};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset_btn = 1'b1;
    touch_btn = 4'hF;
    upd_bus.upd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #4 reset_btn = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (pos_x !== 3'(SX) || pos_y !== 3'(SY)) begin
      errors++; $display("FAIL reset_pos: got (%0d,%0d) want (%0d,%0d)", pos_x, pos_y, SX, SY);
    end
    checks++;
    if (heading !== 2'd1 || z_angle !== 8'd64) begin
      errors++; $display("FAIL reset_head: got %0d/%0d want 1/64", heading, z_angle);
    end
    checks++;
    if (upd_bus.upd_valid !== 1'b0 || upd_bus.upd_kind !== 2'b00 || blocked !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got v=%b k=%b b=%b want 0 00 0",
                         upd_bus.upd_valid, upd_bus.upd_kind, blocked);
    end
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
    end
  endtask

  task automatic test_forward_move();
    int lat;
    lat = 0;
    touch_btn = 4'b1110;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL fwd_trace n=%0d: got %h want %h", n, obs, exp_vec()); end
      if (upd_bus.upd_valid === 1'b1) lat = n;
    end
    checks++;
    if (lat != 8) begin errors++; $display("FAIL fwd_latency: got %0d want 8 cycles", lat); end
    checks++;
    if (pos_x !== 3'd1 || pos_y !== 3'd0 || upd_bus.upd_kind !== 2'b01) begin
      errors++; $display("FAIL fwd_result: got (%0d,%0d) k=%b want (1,0) k=01", pos_x, pos_y, upd_bus.upd_kind);
    end
    touch_btn = 4'hF;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL fwd_hold: got %h want %h", obs, exp_vec()); end
    end
    upd_bus.upd_ready = 1'b1;
    tick();
    upd_bus.upd_ready = 1'b0;
    checks++;
    if (upd_bus.upd_valid !== 1'b0 || upd_bus.upd_kind !== 2'b00) begin
      errors++; $display("FAIL fwd_ack: got v=%b k=%b want 0 00", upd_bus.upd_valid, upd_bus.upd_kind);
    end
    for (int n = 0; n < 12; n++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL fwd_idle: got %h want %h", obs, exp_vec()); end
    end
  endtask

  task automatic test_blocked_move();
    int blk, vcnt;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        ver_wall = '0; ver_wall[2] = 1'b1; touch_btn = 4'b1110;
      end else begin
        apply_reset();
        ver_wall = '0; touch_btn = 4'b1101;
      end
      blk = 0; vcnt = 0;
      for (int n = 0; n < 24; n++) begin
        if (n == 12) touch_btn = 4'hF;
        tick();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL blk_trace p%0d: got %h want %h", pass, obs, exp_vec()); end
        if (blocked === 1'b1) blk++;
        if (upd_bus.upd_valid === 1'b1) vcnt++;
      end
      checks++;
      if (blk != 1 || vcnt != 0) begin
        errors++; $display("FAIL blk_pulse p%0d: got blocked=%0d valid=%0d cycles want 1/0", pass, blk, vcnt);
      end
      checks++;
      if (pos_x !== 3'(1 - pass) || pos_y !== 3'd0 || heading !== 2'd1) begin
        errors++; $display("FAIL blk_pos p%0d: got (%0d,%0d) h%0d want (%0d,0) h1", pass, pos_x, pos_y, heading, 1 - pass);
      end
    end
  endtask

  task automatic test_rotate();
    logic [3:0] seq [4];
    int vcnt;
    logic [1:0] kseen;
    seq[0] = 4'b0111; seq[1] = 4'b0111; seq[2] = 4'b0111; seq[3] = 4'b1011;
    upd_bus.upd_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      vcnt = 0; kseen = 2'b00;
      touch_btn = seq[s];
      for (int n = 0; n < 20; n++) begin
        if (n == 10) touch_btn = 4'hF;
        tick();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL rot_trace s%0d: got %h want %h", s, obs, exp_vec()); end
        if (upd_bus.upd_valid === 1'b1) begin vcnt++; kseen = upd_bus.upd_kind; end
      end
      checks++;
      if (vcnt != 1 || kseen !== 2'b10) begin
        errors++; $display("FAIL rot_upd s%0d: got %0d cycles k=%b want 1 cycle k=10", s, vcnt, kseen);
      end
      if (s == 2) begin
        checks++;
        if (heading !== 2'd0 || z_angle !== 8'd0) begin
          errors++; $display("FAIL rot_right_wrap: got %0d/%0d want 0/0", heading, z_angle);
        end
      end
    end
    checks++;
    if (heading !== 2'd3 || z_angle !== 8'd192) begin
      errors++; $display("FAIL rot_left_wrap: got %0d/%0d want 3/192", heading, z_angle);
    end
  endtask

  task automatic test_glitch_priority();
    int vcnt;
    logic [1:0] kseen;
    apply_reset();
    upd_bus.upd_ready = 1'b1;
    vcnt = 0;
    touch_btn = 4'b1110;
    for (int n = 0; n < 18; n++) begin
      if (n == 3) touch_btn = 4'hF;
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL glitch_trace: got %h want %h", obs, exp_vec()); end
      if (upd_bus.upd_valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt != 0) begin errors++; $display("FAIL glitch_no_update: got %0d valid cycles want 0", vcnt); end
    kseen = 2'b00;
    touch_btn = 4'b1010;
    for (int n = 0; n < 20; n++) begin
      if (n == 10) touch_btn = 4'hF;
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL prio_trace: got %h want %h", obs, exp_vec()); end
      if (upd_bus.upd_valid === 1'b1) kseen = upd_bus.upd_kind;
    end
    checks++;
    if (pos_x !== 3'd1 || heading !== 2'd1 || kseen !== 2'b01) begin
      errors++; $display("FAIL prio_move_only: got x=%0d h=%0d k=%b want x=1 h=1 k=01", pos_x, heading, kseen);
    end
    upd_bus.upd_ready = 1'b0;
  endtask

  task automatic test_wait_drop();
    bit got;
    logic [19:0] held;
    got = 0;
    upd_bus.upd_ready = 1'b0;
    touch_btn = 4'b1110;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL wait_enter: got %h want %h", obs, exp_vec()); end
      if (upd_bus.upd_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL wait_timeout: got no upd_valid want upd_valid within 20 cycles"); end
    held = {3'd2, 3'd0, 2'd1, 8'd64, 1'b1, 2'b01, 1'b0};
    touch_btn = 4'hF;
    for (int n = 0; n < 26; n++) begin
      if (n == 6)  touch_btn = 4'b0111;
      if (n == 18) touch_btn = 4'hF;
      tick();
      checks++;
      if (obs !== held) begin errors++; $display("FAIL wait_stable: got %h want %h", obs, held); end
    end
    upd_bus.upd_ready = 1'b1;
    tick();
    upd_bus.upd_ready = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL wait_after: got %h want %h", obs, exp_vec()); end
    end
    checks++;
    if (heading !== 2'd1 || pos_x !== 3'd2 || upd_bus.upd_valid !== 1'b0) begin
      errors++; $display("FAIL wait_dropped: got h=%0d x=%0d v=%b want h=1 x=2 v=0", heading, pos_x, upd_bus.upd_valid);
    end
  endtask

  task automatic test_async_reset();
    bit got;
    got = 0;
    upd_bus.upd_ready = 1'b0;
    touch_btn = 4'b1110;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL arst_enter: got %h want %h", obs, exp_vec()); end
      if (upd_bus.upd_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got || pos_x !== 3'd3) begin errors++; $display("FAIL arst_setup: got v=%b x=%0d want v=1 x=3", got, pos_x); end
    touch_btn = 4'hF;
    #2 reset_btn = 1'b1;
    #1;
    checks++;
    if (upd_bus.upd_valid !== 1'b0 || upd_bus.upd_kind !== 2'b00 || pos_x !== 3'(SX) || pos_y !== 3'(SY)
        || heading !== 2'(SH)) begin
      errors++; $display("FAIL arst_immediate: got v=%b k=%b (%0d,%0d) h%0d want 0 00 (%0d,%0d) h%0d",
                         upd_bus.upd_valid, upd_bus.upd_kind, pos_x, pos_y, heading, SX, SY, SH);
    end
    model_reset();
    @(posedge clk_in);
    #4 reset_btn = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL arst_after: got %h want %h", obs, exp_vec()); end
    end
  endtask

  task automatic test_random();
    int b;
    for (int n = 0; n < 1200; n++) begin
      if (n % 64 == 0) begin
        hor_wall = 30'($urandom & $urandom & $urandom);
        ver_wall = 30'($urandom & $urandom & $urandom);
      end
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, 3);
        touch_btn[b] = ~touch_btn[b];
      end
      upd_bus.upd_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL rand n=%0d: got %h want %h", n, obs, exp_vec()); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    upd_bus.upd_ready = 1'b0;
    test_reset();
    test_forward_move();
    test_blocked_move();
    test_rotate();
    test_glitch_priority();
    test_wait_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
